// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [4:0]  OPC_HALT = 5'b11111;
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 27;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHalt
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so push into a full FIFO is legal then.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory handshake, redirect and HALT handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] Instr,
    output logic        halted
);

    localparam int unsigned   CntW    = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthM1 = CntW'(DEPTH - 1);

    fetch_state_t    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            drop_q, drop_d;

    logic            fifo_push, fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    fetch_entry_t    fifo_entry, fifo_head;
    logic            room_after_push;

    assign fifo_pop        = !fifo_empty && !stall;
    assign fifo_flush      = redirect;
    assign room_after_push = fifo_pop || (fifo_count < DepthM1);

    always_comb begin
        fifo_entry.pc    = req_pc_q;
        fifo_entry.instr = imem_rdata;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        drop_d    = drop_q;
        fifo_push = 1'b0;

        if (redirect) begin
            pc_d = redirect_pc;
            unique case (state_q)
                StReq: begin
                    // A granted request still has a response in flight that must be discarded.
                    if (imem_gnt) begin
                        state_d = StWait;
                        drop_d  = 1'b1;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_full) state_d = StReq;
                end
                StReq: begin
                    if (imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = StReq;
                        end else begin
                            fifo_push = 1'b1;
                            if (imem_rdata[OPC_MSB:OPC_LSB] == OPC_HALT) begin
                                state_d = StHalt;
                            end else if (room_after_push) begin
                                state_d = StReq;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .push      (fifo_push),
        .push_data (fifo_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = imem_req ? pc_q : '0;
    assign halted      = (state_q == StHalt);
    assign instr_valid = !fifo_empty;
    assign pc_out      = fifo_head.pc;
    assign Instr       = fifo_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple fixed-latency instruction memory responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] Instr;
    logic        halted;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat = 1;
    int          resp_cnt = 0;
    logic [31:0] resp_addr = '0;
    bit          halt_en = 1'b0;
    bit          seen8 = 1'b0;
    int          n_gnt = 0;

    fetch_unit #(
        .RESET_PC (32'h0),
        .PC_STEP  (32'd4),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .Instr       (Instr),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == 32'h10) return 32'hF800_0000;
        return {12'h0A5, a[19:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: step past the edge, then play memory for this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(resp_addr);
            end
        end
        imem_gnt = imem_req;
        if (imem_gnt) begin
            n_gnt++;
            resp_cnt  = lat;
            resp_addr = imem_addr;
        end
        if (instr_valid && pc_out == 32'h8) seen8 = 1'b1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        resp_cnt    = 0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        n_gnt = 0;
    endtask

    initial begin
        // Sequential fetch, single-cycle grant and response
        do_reset();
        lat = 1;
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_instr", Instr, 0);
        tick();
        check("seq_req0", 32'(imem_req), 1);
        check("seq_addr0", imem_addr, 32'h0);
        tick();
        check("seq_valid_early", 32'(instr_valid), 0);
        tick();
        check("seq_valid0", 32'(instr_valid), 1);
        check("seq_pc0", pc_out, 32'h0);
        check("seq_instr0", Instr, 32'h0A50_0000);
        check("seq_addr4", imem_addr, 32'h4);
        ticks(2);
        check("seq_pc4", pc_out, 32'h4);
        check("seq_instr4", Instr, 32'h0A50_0004);
        check("seq_addr8", imem_addr, 32'h8);
        ticks(2);
        check("seq_pc8", pc_out, 32'h8);
        check("seq_instr8", Instr, 32'h0A50_0008);

        // Backpressure: FIFO fills with two entries, then fetch resumes
        do_reset();
        stall = 1'b1;
        ticks(9);
        check("stall_grants", 32'(n_gnt), 2);
        check("stall_req_off", 32'(imem_req), 0);
        check("stall_head", pc_out, 32'h0);
        stall = 1'b0;
        tick();
        check("drain_pc4", pc_out, 32'h4);
        check("drain_req_off", 32'(imem_req), 0);
        tick();
        check("resume_req", 32'(imem_req), 1);
        check("resume_addr", imem_addr, 32'h8);
        check("resume_empty", 32'(instr_valid), 0);
        ticks(2);
        check("resume_pc8", pc_out, 32'h8);

        // Redirect while waiting on 0x8: its response must be dropped
        do_reset();
        lat   = 3;
        seen8 = 1'b0;
        ticks(9);
        check("redir_addr8", imem_addr, 32'h8);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("redir_wait_req", 32'(imem_req), 0);
        check("redir_flushed", 32'(instr_valid), 0);
        ticks(2);
        check("redir_req", 32'(imem_req), 1);
        check("redir_addr", imem_addr, 32'h100);
        ticks(4);
        check("redir_pc", pc_out, 32'h100);
        check("redir_instr", Instr, 32'h0A50_0100);
        check("redir_no8", 32'(seen8), 0);

        // HALT at 0x10, then redirect to 0x20 restarts fetch
        do_reset();
        lat     = 1;
        halt_en = 1'b1;
        ticks(9);
        check("halt_addr10", imem_addr, 32'h10);
        ticks(2);
        check("halt_flag", 32'(halted), 1);
        check("halt_valid", 32'(instr_valid), 1);
        check("halt_pc", pc_out, 32'h10);
        check("halt_instr", Instr, 32'hF800_0000);
        check("halt_req_off", 32'(imem_req), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_quiet", 32'(imem_req), 0);
            check("halt_hold", 32'(halted), 1);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        check("unhalt_flag", 32'(halted), 0);
        check("unhalt_req", 32'(imem_req), 1);
        check("unhalt_addr", imem_addr, 32'h20);
        check("unhalt_valid", 32'(instr_valid), 0);
        halt_en = 1'b0;

        // PC wraps past 0xFFFFFFFC
        do_reset();
        lat         = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wrap_req", 32'(imem_req), 1);
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        ticks(2);
        check("wrap_addr0", imem_addr, 32'h0);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_instr", Instr, 32'h0A5F_FFFC);

        // Reset during WAIT, late response after release is ignored
        do_reset();
        lat = 5;
        ticks(2);
        Reset    = 1'b1;
        resp_cnt = 0;
        #1;
        check("midrst_req", 32'(imem_req), 0);
        check("midrst_valid", 32'(instr_valid), 0);
        tick();
        Reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0A50_0000;
        check("late_req", 32'(imem_req), 0);
        tick();
        check("late_valid", 32'(instr_valid), 0);
        check("late_req_on", 32'(imem_req), 1);
        check("late_addr", imem_addr, 32'h0);
        check("late_pc_out", pc_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the fetch-to-decode pipeline register: owns the program counter, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small FIFO. It presents `pc_out`/`Instr` pairs to decode with a valid/stall handshake. It also accepts branch redirects from later stages and stops fetching on a HALT opcode.

## Interface
- `RESET_PC`, 32'h0, PC loaded on reset
- `PC_STEP`, 4, byte increment between sequential fetches
- `DEPTH`, 2, instruction FIFO entries (power of two, ≥2)
- `clk`  in  1  clock; all state on posedge
- `Reset`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  request to instruction memory
- `imem_addr`  out  32  request address (the fetch PC)
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  instruction word
- `redirect`  in  1  branch/jump taken; flush and refetch
- `redirect_pc`  in  32  target PC, sampled when `redirect`=1
- `stall`  in  1  decode cannot accept this cycle
- `instr_valid`  out  1  FIFO head is valid
- `pc_out`  out  32  PC of FIFO head
- `Instr`  out  32  instruction of FIFO head
- `halted`  out  1  HALT fetched; no further requests

## Operation
- States: IDLE, REQ, WAIT, HALT. Reset → IDLE. All outputs are 0 during and immediately after reset. PC = `RESET_PC`.
- IDLE → REQ when `count + 0 < DEPTH`, where `count` is the FIFO occupancy. Only one request is outstanding at a time.
- REQ: `imem_req`=1, `imem_addr`=PC. `imem_addr` is held stable until `imem_gnt`. On `imem_gnt`: PC += `PC_STEP` (mod 2^32, wraps), go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`: push {addr, `imem_rdata`} into the FIFO.
  - If `imem_rdata[31:27]` == `OPC_HALT` (5'b11111), go to HALT.
  - Otherwise go to REQ if the FIFO has room after this push, else IDLE.
- HALT: `halted`=1, no requests. Buffered entries still drain to decode.
- Dequeue: the FIFO head pops when `instr_valid` && !`stall`. Push and pop in the same cycle on a full FIFO is allowed. When the FIFO is empty, `pc_out`=0 and `Instr`=0.
- `imem_rvalid` outside WAIT is ignored.
- Redirect, which has the highest priority in every state:
  - Flush the FIFO and set PC = `redirect_pc`. Clear `halted`.
  - From REQ with no grant this cycle: next cycle, REQ with the new address.
  - From WAIT, or from REQ with a grant this cycle: set `drop`. The pending response is discarded. Then REQ to `redirect_pc` on the cycle after that response.
  - From IDLE or HALT: go to REQ.
  - A redirect coinciding with `imem_rvalid` discards that response.
  - A redirect coinciding with a dequeue flushes the FIFO; the popped entry is still considered consumed by decode.
- `Reset` mid-transaction: state, FIFO, `drop`, PC all cleared asynchronously. A late `imem_rvalid` after reset is ignored (state IDLE).

## Timing
- Reset release at edge E: IDLE at E, `imem_req`=1 with `RESET_PC` from E+1.
- Grant at cycle N, `imem_rvalid` at cycle M > N: `instr_valid`=1 with the entry at M+1 (registered push, 1-cycle latency). There is no combinational path from `imem_rdata` to `Instr`.
- Redirect at N with nothing outstanding: `imem_req`=1, `imem_addr`=`redirect_pc` at N+1. `instr_valid`=0 at N+1.
- Steady-state throughput: with single-cycle grant and response, 1 instruction per 2 cycles.
- `stall` only blocks the pop. Fetch continues until `count`+outstanding = `DEPTH`.

## Structure
- Package `fetch_pkg`:
  - `OPC_HALT`
  - opcode field bounds [31:27]
  - `fetch_state_t` enum {IDLE, REQ, WAIT, HALT}
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}
- Sub-module `fetch_fifo`: parameterised `DEPTH`, with push/pop/flush, full/empty/count, and wrap-around read/write pointers.
- The FSM, PC register, and `drop` flag live in `fetch_unit`.

## Test plan
- Reset, `imem_gnt`=1, `imem_rvalid` one cycle after grant, `stall`=0 → fetches at 0x0, 0x4, 0x8. `pc_out`/`Instr` match memory in order. `instr_valid` is first high 3 cycles after reset release.
- Hold `stall`=1 with `DEPTH`=2 → exactly two requests issue, then `imem_req` stays 0. Release `stall` → entries 0x0, 0x4 drain, then fetching resumes at 0x8.
- Redirect to 0x100 while in WAIT for 0x8 → the 0x8 response is dropped, the next `imem_addr`=0x100, and no 0x8 entry ever appears at `Instr`.
- Fetch word 0xF8000000 (HALT) at 0x10 → `halted`=1 and no further `imem_req`. The HALT entry is presented. A redirect to 0x20 clears `halted` and fetches 0x20.
- PC 0xFFFFFFFC granted → next `imem_addr`=0x00000000.
- Assert `Reset` during WAIT, then drive `imem_rvalid` the cycle after release → response ignored, FIFO empty, request to `RESET_PC`.
